// File: rtl/rng_pkg.sv
// Shared constants and pairing-FSM encoding for the RNG post-processor.
package rng_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned RCT_CUTOFF_DEF = 32;

  typedef enum logic {
    StWaitFirst  = 1'b0,
    StWaitSecond = 1'b1
  } pair_state_e;

endpackage

// File: rtl/rng_rct.sv
// Repetition-count health test: sticky fail once a run of identical samples reaches RCT_CUTOFF.
module rng_rct
  import rng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic sample,
  input  logic valid,
  input  logic clear,
  output logic fail
);

  localparam logic [7:0] Cutoff = 8'(RCT_CUTOFF);

  logic [7:0] r_run;
  logic       r_last;
  logic       r_fail;
  logic [7:0] w_run_d;

  // A zero count means no sample seen since reset/clear, so the first one always starts a run.
  always_comb begin
    w_run_d = r_run;
    if (r_run == 8'd0 || sample != r_last) begin
      w_run_d = 8'd1;
    end else if (r_run < Cutoff) begin
      w_run_d = r_run + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_run  <= 8'd0;
      r_last <= 1'b0;
      r_fail <= 1'b0;
    end else if (valid) begin
      r_run  <= w_run_d;
      r_last <= sample;
      if (w_run_d == Cutoff) begin
        r_fail <= 1'b1;
      end
    end
  end

  assign fail = r_fail;

endmodule

// File: rtl/rng_postproc.sv
// Von Neumann whitener with LSB-first byte packer, single-entry output slot and
// repetition-count health monitoring.
module rng_postproc
  import rng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              clr_flags,
  output logic [BYTE_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              health_fail,
  output logic              overflow
);

  pair_state_e       r_state, w_state_d;
  logic              r_first, w_first_d;
  logic [BYTE_W-1:0] r_shift, w_shift_d;
  logic [2:0]        r_cnt, w_cnt_d;
  logic [BYTE_W-1:0] r_dout, w_dout_d;
  logic              r_valid, w_valid_d;
  logic              r_ovf, w_ovf_d;
  logic              w_fail;
  logic              w_take;
  logic              w_emit;
  logic              w_bit;
  logic              w_complete;
  logic [BYTE_W-1:0] w_byte;

  rng_rct #(
    .RCT_CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk   (clk),
    .rst   (rst),
    .sample(bit_in),
    .valid (sample_en),
    .clear (clr_flags),
    .fail  (w_fail)
  );

  assign w_take = sample_en & ~clr_flags & ~w_fail;

  always_comb begin
    w_state_d  = r_state;
    w_first_d  = r_first;
    w_shift_d  = r_shift;
    w_cnt_d    = r_cnt;
    w_dout_d   = r_dout;
    w_valid_d  = r_valid;
    w_ovf_d    = r_ovf;
    w_emit     = 1'b0;
    w_bit      = 1'b0;
    w_complete = 1'b0;
    w_byte     = r_shift;

    if (w_take) begin
      unique case (r_state)
        StWaitFirst: begin
          w_first_d = bit_in;
          w_state_d = StWaitSecond;
        end
        StWaitSecond: begin
          w_state_d = StWaitFirst;
          if (r_first != bit_in) begin
            w_emit = 1'b1;
            w_bit  = r_first;
          end
        end
        default: w_state_d = StWaitFirst;
      endcase
    end

    if (w_emit) begin
      w_byte[r_cnt] = w_bit;
      w_shift_d     = w_byte;
      w_cnt_d       = r_cnt + 3'd1;
      w_complete    = (r_cnt == 3'd7);
    end

    if (dout_valid && dout_ready) begin
      w_valid_d = 1'b0;
    end

    if (w_complete) begin
      if (!dout_valid || dout_ready) begin
        w_dout_d  = w_byte;
        w_valid_d = 1'b1;
      end else begin
        w_ovf_d = 1'b1;
      end
    end

    // A failed health test flushes any partial or held data until cleared.
    if (w_fail || clr_flags) begin
      w_state_d = StWaitFirst;
      w_cnt_d   = 3'd0;
      w_shift_d = '0;
      w_valid_d = 1'b0;
    end
    if (clr_flags) begin
      w_ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StWaitFirst;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_first <= 1'b0;
      r_shift <= '0;
      r_cnt   <= 3'd0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_first <= w_first_d;
      r_shift <= w_shift_d;
      r_cnt   <= w_cnt_d;
      r_dout  <= w_dout_d;
      r_valid <= w_valid_d;
      r_ovf   <= w_ovf_d;
    end
  end

  assign dout        = r_dout;
  assign dout_valid  = r_valid & ~w_fail;
  assign health_fail = w_fail;
  assign overflow    = r_ovf;

endmodule

// File: tb/tb_rng_postproc.sv
// Directed bench for rng_postproc with hand-computed expectations.
module tb_rng_postproc;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_en = 1'b0;
  logic       bit_in = 1'b0;
  logic       clr_flags = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       health_fail;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  rng_postproc #(
    .RCT_CUTOFF(32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sample_en  (sample_en),
    .bit_in     (bit_in),
    .clr_flags  (clr_flags),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .health_fail(health_fail),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic b);
    sample_en = en;
    bit_in    = b;
    @(posedge clk);
    #1;
    sample_en = 1'b0;
  endtask

  // Byte bit i is sent as pair (bit, ~bit): 1 -> "10", 0 -> "01".
  task automatic feed(input logic [7:0] val, input int from, input int upto);
    logic s;
    for (int k = from; k <= upto; k++) begin
      s = val[k >> 1];
      if (k % 2 == 1) s = ~s;
      step(1'b1, s);
    end
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1;
    step(1'b0, 1'b0);
    clr_flags = 1'b0;
  endtask

  logic seen_valid;

  initial begin
    // Reset state
    rst = 1'b1;
    step(1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_dout", dout, 8'h00);
    chk("rst_valid", {7'd0, dout_valid}, 8'd0);
    chk("rst_hfail", {7'd0, health_fail}, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);

    // Basic byte: valid appears only after the 16th sample
    feed(8'h8D, 0, 14);
    chk("b1_valid_early", {7'd0, dout_valid}, 8'd0);
    feed(8'h8D, 15, 15);
    chk("b1_valid", {7'd0, dout_valid}, 8'd1);
    chk("b1_dout", dout, 8'h8D);
    dout_ready = 1'b1;
    step(1'b0, 1'b0);
    chk("b1_consumed", {7'd0, dout_valid}, 8'd0);

    // 00/11 pairs emit nothing and never trip the health test
    seen_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'((i >> 1) & 1));
      seen_valid |= dout_valid;
    end
    chk("eq_pairs_valid", {7'd0, seen_valid}, 8'd0);
    chk("eq_pairs_hfail", {7'd0, health_fail}, 8'd0);

    // Backpressure overflow
    dout_ready = 1'b0;
    feed(8'h8D, 0, 15);
    chk("ov_first_dout", dout, 8'h8D);
    chk("ov_first_ovf", {7'd0, overflow}, 8'd0);
    feed(8'h72, 0, 15);
    chk("ov_held_dout", dout, 8'h8D);
    chk("ov_held_valid", {7'd0, dout_valid}, 8'd1);
    chk("ov_flag", {7'd0, overflow}, 8'd1);
    dout_ready = 1'b1;
    step(1'b0, 1'b0);
    chk("ov_accept_valid", {7'd0, dout_valid}, 8'd0);
    chk("ov_sticky", {7'd0, overflow}, 8'd1);
    pulse_clr();
    chk("clr_ovf", {7'd0, overflow}, 8'd0);

    // Consume and reload at the same edge
    dout_ready = 1'b0;
    feed(8'h8D, 0, 15);
    feed(8'h72, 0, 14);
    chk("sim_held", dout, 8'h8D);
    dout_ready = 1'b1;
    feed(8'h72, 15, 15);
    chk("sim_dout", dout, 8'h72);
    chk("sim_valid", {7'd0, dout_valid}, 8'd1);
    chk("sim_ovf", {7'd0, overflow}, 8'd0);
    step(1'b0, 1'b0);
    chk("sim_drain", {7'd0, dout_valid}, 8'd0);

    // Repetition-count failure at exactly 32 identical samples
    dout_ready = 1'b0;
    pulse_clr();
    for (int i = 0; i < 31; i++) step(1'b1, 1'b1);
    chk("rct_31", {7'd0, health_fail}, 8'd0);
    step(1'b1, 1'b1);
    chk("rct_32", {7'd0, health_fail}, 8'd1);
    chk("rct_valid", {7'd0, dout_valid}, 8'd0);
    feed(8'h8D, 0, 15);
    chk("rct_ignored", {7'd0, dout_valid}, 8'd0);
    chk("rct_sticky", {7'd0, health_fail}, 8'd1);
    pulse_clr();
    chk("rct_cleared", {7'd0, health_fail}, 8'd0);
    feed(8'h8D, 0, 15);
    chk("rct_after_dout", dout, 8'h8D);
    chk("rct_after_valid", {7'd0, dout_valid}, 8'd1);

    // Reset mid-byte drops leftover bits and beats an active sample
    dout_ready = 1'b1;
    step(1'b0, 1'b0);
    feed(8'h72, 0, 9);
    rst       = 1'b1;
    clr_flags = 1'b1;
    step(1'b1, 1'b1);
    rst       = 1'b0;
    clr_flags = 1'b0;
    chk("mid_rst_dout", dout, 8'h00);
    chk("mid_rst_valid", {7'd0, dout_valid}, 8'd0);
    dout_ready = 1'b0;
    feed(8'h8D, 0, 15);
    chk("mid_rst_byte", dout, 8'h8D);
    chk("mid_rst_bvalid", {7'd0, dout_valid}, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
